// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the CPU command sequencer: opcode constants, the
// queued command record and the sequencer FSM state encoding.
// Build option: define CPU_SEQ_BURST_EN to enable repeated load/store bursts.
package cpu_seq_pkg;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_MUL   = 3'b011;
  localparam logic [2:0] OP_INIT  = 3'b100;
  localparam logic [2:0] OP_NOP   = 3'b111;

  // One queued host command ("reg" is a keyword, hence reg_sel).
  typedef struct packed {
    logic [2:0]   op;
    logic [1:0]   reg_sel;
    logic [8:0]   addr;
    logic [511:0] data;
    logic [3:0]   count;
  } cmd_t;

`ifdef CPU_SEQ_BURST_EN
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_BURST} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE} state_t;
`endif

  // Opcodes 101/110/111 are accepted by the host port but never issued.
  function automatic logic op_valid(input logic [2:0] op);
    return op <= OP_INIT;
  endfunction

  function automatic logic is_mem_op(input logic [2:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO, DEPTH entries of cmd_t, async active-high reset.
// Latency: an entry pushed at edge E is visible on pop_data after E; read is combinational from the head.
// Backpressure: push ignored while full, pop ignored while empty; no bypass when full.
// Ports: clk, rst, push/push_data (write side), pop/pop_data (read side), full, empty.
module cmd_fifo
  import cpu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  cmd_t push_data,
  input  logic pop,
  output cmd_t pop_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  cmd_t        mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Queues host commands and issues them to the CPU one per cycle, in order.
// Latency: command accepted at edge E into an empty queue drives the CPU after edge E+1.
// Backpressure: cmd_ready = !fifo_full (low during reset and for the first edge after it).
// Ports: clk, rst; host side cmd_valid/cmd_ready/cmd_op/cmd_reg/cmd_addr/cmd_data/cmd_count;
// CPU side instruction/reg_addr/mem_address/initialize_value (registered); busy, issued_count.
// Build option: CPU_SEQ_BURST_EN makes load/store repeat cmd_count+1 times with incrementing address.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [1:0]   cmd_reg,
  input  logic [8:0]   cmd_addr,
  input  logic [511:0] cmd_data,
  input  logic [3:0]   cmd_count,
  output logic [2:0]   instruction,
  output logic [1:0]   reg_addr,
  output logic [8:0]   mem_address,
  output logic [511:0] initialize_value,
  output logic         busy,
  output logic [15:0]  issued_count
);

  cmd_t   push_cmd;
  cmd_t   head;
  logic   fifo_full;
  logic   fifo_empty;
  logic   pop;
  logic   ready_en;
  logic   burst_more;
  state_t state;

  assign push_cmd  = '{op: cmd_op, reg_sel: cmd_reg, addr: cmd_addr, data: cmd_data, count: cmd_count};
  // ready_en holds cmd_ready low until the first edge after reset release.
  assign cmd_ready = ready_en && !fifo_full;
  assign busy      = !fifo_empty || (state != ST_IDLE);

`ifdef CPU_SEQ_BURST_EN
  logic [3:0] burst_rem;  // beats still to issue after the one on the outputs
  assign burst_more = (burst_rem != 4'd0);
`else
  logic unused_bits;
  assign burst_more  = 1'b0;
  assign unused_bits = ^head.count;
`endif

  // The head is consumed whenever no burst beat is pending, in any state.
  assign pop = !fifo_empty && !burst_more;

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_valid),
    .push_data (push_cmd),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      ready_en         <= 1'b0;
      instruction      <= OP_NOP;
      reg_addr         <= '0;
      mem_address      <= '0;
      initialize_value <= '0;
      issued_count     <= '0;
`ifdef CPU_SEQ_BURST_EN
      burst_rem        <= '0;
`endif
    end else begin
      ready_en <= 1'b1;
      if (instruction != OP_NOP && issued_count != 16'hFFFF)
        issued_count <= issued_count + 16'd1;

`ifdef CPU_SEQ_BURST_EN
      if (burst_more) begin
        // Repeat the same load/store; address wraps 511 -> 0 naturally.
        state       <= ST_BURST;
        mem_address <= mem_address + 9'd1;
        burst_rem   <= burst_rem - 4'd1;
      end else
`endif
      if (pop && op_valid(head.op)) begin
        state            <= ST_ISSUE;
        instruction      <= head.op;
        reg_addr         <= head.reg_sel;
        mem_address      <= head.addr;
        initialize_value <= (head.op == OP_INIT) ? head.data : '0;
`ifdef CPU_SEQ_BURST_EN
        burst_rem        <= is_mem_op(head.op) ? head.count : 4'd0;
`endif
      end else begin
        // Nothing to issue, or an invalid opcode was popped and dropped.
        state            <= ST_IDLE;
        instruction      <= OP_NOP;
        reg_addr         <= '0;
        mem_address      <= '0;
        initialize_value <= '0;
      end
    end
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter: DEPTH, 4, command FIFO entries (power of two, 2..16).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  host command present.
REQ-005 cmd_ready  output  1  sequencer accepts command this cycle.
REQ-006 cmd_op  input  3  opcode: load 000, store 001, add 010, mul 011, init 100.
REQ-007 cmd_reg  input  2  register select.
REQ-008 cmd_addr  input  9  memory word address.
REQ-009 cmd_data  input  512  init value.
REQ-010 cmd_count  input  4  burst repeat count (used only under REQ-031).
REQ-011 instruction  output  3  opcode driven to CPU; NOP = 3'b111 (writes neither register file nor memory).
REQ-012 reg_addr  output  2  register select to CPU.
REQ-013 mem_address  output  9  memory address to CPU.
REQ-014 initialize_value  output  512  init data to CPU.
REQ-015 busy  output  1  high while FIFO non-empty or a command/burst is issuing.
REQ-016 issued_count  output  16  number of non-NOP cycles issued, saturating at 0xFFFF.

Function
REQ-017 Handshake: transfer when cmd_valid && cmd_ready; cmd_ready = !fifo_full, no same-cycle push-on-pop bypass when full.
REQ-018 Accepted opcodes 101/110/111 are written to the FIFO, then dropped when popped: zero issue cycles, not counted.
REQ-019 All CPU-side outputs are registered; outputs not issuing a command hold instruction=111 with reg_addr, mem_address, initialize_value = 0.
REQ-020 FSM states: IDLE (drive NOP), ISSUE (drive head command), BURST (drive repeated load/store).
REQ-021 IDLE -> ISSUE at the edge where FIFO is non-empty; head is popped and loaded into output registers at that edge.
REQ-022 Latency: command accepted at edge E into empty FIFO appears on outputs after edge E+1 (2 cycles valid-to-instruction).
REQ-023 ISSUE lasts one cycle per command; back-to-back commands issue in consecutive cycles with no NOP bubble.
REQ-024 ISSUE -> IDLE when FIFO empty and no burst pending; ISSUE -> BURST when burst remaining > 0.
REQ-025 Commands issue strictly in acceptance order.
REQ-026 issued_count increments in each cycle instruction != 111; holds at 0xFFFF.

Reset
REQ-027 While rst high: cmd_ready=0, instruction=111, reg_addr=0, mem_address=0, initialize_value=0, busy=0, issued_count=0, FIFO empty, state IDLE.
REQ-028 Reset mid-burst or with FIFO occupied discards all pending commands; first cycle after release drives NOP.
REQ-029 Reset release needs no synchronisation inside this block; cmd_ready rises on the first edge after release.

Configuration
REQ-030 Macro CPU_SEQ_BURST_EN selects burst support.
REQ-031 With CPU_SEQ_BURST_EN: load/store issues cmd_count+1 times on consecutive cycles, mem_address +1 each cycle, wrapping 511 -> 0; reg_addr, opcode fixed; other opcodes ignore cmd_count.
REQ-032 Without CPU_SEQ_BURST_EN: cmd_count ignored, BURST state absent, every command issues exactly once.

Structure
REQ-033 Shared package cpu_seq_pkg holds opcode constants (OP_LOAD, OP_STORE, OP_ADD, OP_MUL, OP_INIT, OP_NOP), command struct typedef (op, reg, addr, data, count), FSM state enum.
REQ-034 One sub-module cmd_fifo (synchronous FIFO, DEPTH entries of the command struct, full/empty flags, async active-high reset).

Verification
REQ-035 Single load op=000 reg=2 addr=0x05 into idle block -> after 2 cycles instruction=000, reg_addr=2, mem_address=0x05 for exactly one cycle, then 111; issued_count=1.
REQ-036 Push DEPTH+1 commands with cmd_valid held, no draining stall -> cmd_ready low while full, all DEPTH+1 issue in order, no NOP gaps once started.
REQ-037 Init op=100 reg=1 data=all-ones, then op=110 -> init issued one cycle, invalid op produces no issue cycle, issued_count=1.
REQ-038 Burst (macro on) store reg=3 addr=510 count=3 -> store at 510, 511, 0, 1 on four consecutive cycles; macro off -> single store at 510.
REQ-039 Assert rst during cycle 2 of a 4-beat burst with 2 queued commands -> outputs reset immediately, no further issue after release, busy=0.
REQ-040 Force issued_count to 0xFFFE via 0xFFFE issues, issue 3 more -> issued_count holds 0xFFFF.
